// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the datapath controller and muldiv_unit.
// WIDTH must match the WIDTH of the muldiv_unit it connects to.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Sequential MULT/MULTU/DIV/DIVU unit with HI/LO registers (radix-2, one step per cycle).
// Optional MULDIV_EARLY_OUT_EN: multiplies leave CALC once the multiplier shift register is empty.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic          clk,
  input logic          reset_n,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_r;
  logic               busy_r;
  logic               done_r;
  logic               dz_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               is_div_r;
  logic               dz_pend_r;
  logic               neg_res_r;
  logic               neg_rem_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [2*WIDTH-1:0] mcand_r;
  // Multiplier for multiplies; dividend shifting out / quotient shifting in for divides.
  logic [WIDTH-1:0]   mplier_r;
  logic [WIDTH-1:0]   divisor_r;
  logic [WIDTH-1:0]   rem_r;

  logic               is_signed_s;
  logic               neg_a_s;
  logic               neg_b_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic               b_zero_s;
  logic               wr_ok_s;
  logic [WIDTH:0]     rem_shift_s;
  logic               rem_ge_s;
  logic [WIDTH-1:0]   rem_diff_s;
  logic [WIDTH-1:0]   rem_next_s;
  logic [WIDTH-1:0]   quo_next_s;
  logic [2*WIDTH-1:0] prod_next_s;
  logic               cnt_last_s;
  logic               mul_empty_s;

  assign is_signed_s = ~bus.op[0];
  assign neg_a_s     = is_signed_s & bus.a[WIDTH-1];
  assign neg_b_s     = is_signed_s & bus.b[WIDTH-1];
  assign abs_a_s     = neg_a_s ? neg_w(bus.a) : bus.a;
  assign abs_b_s     = neg_b_s ? neg_w(bus.b) : bus.b;
  assign b_zero_s    = (bus.b == {WIDTH{1'b0}});
  assign wr_ok_s     = ~busy_r;

  // Restoring divide step: the remainder never exceeds the divisor, so the difference fits WIDTH bits.
  assign rem_shift_s = {rem_r, mplier_r[WIDTH-1]};
  assign rem_ge_s    = (rem_shift_s >= {1'b0, divisor_r});
  assign rem_diff_s  = rem_shift_s[WIDTH-1:0] - divisor_r;
  assign rem_next_s  = rem_ge_s ? rem_diff_s : rem_shift_s[WIDTH-1:0];
  assign quo_next_s  = {mplier_r[WIDTH-2:0], rem_ge_s};

  assign prod_next_s = mplier_r[0] ? (prod_r + mcand_r) : prod_r;
  assign cnt_last_s  = (cnt_r == CNT_ONE);

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_empty_s = ~is_div_r & (mplier_r == {WIDTH{1'b0}});
`else
  assign mul_empty_s = 1'b0;
`endif

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dz_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dz_r      <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      dz_pend_r <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      prod_r    <= {(2*WIDTH){1'b0}};
      mcand_r   <= {(2*WIDTH){1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      divisor_r <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      if (bus.hi_we && wr_ok_s) hi_r <= bus.wdata;
      if (bus.lo_we && wr_ok_s) lo_r <= bus.wdata;

      case (state_r)
        IDLE, DONE: begin
          if (bus.start) begin
            busy_r    <= 1'b1;
            dz_r      <= 1'b0;
            is_div_r  <= bus.op[1];
            neg_res_r <= neg_a_s ^ neg_b_s;
            neg_rem_r <= neg_a_s;
            cnt_r     <= CNT_INIT;
            prod_r    <= {(2*WIDTH){1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            if (bus.op[1]) begin
              mcand_r   <= {(2*WIDTH){1'b0}};
              mplier_r  <= abs_a_s;
              divisor_r <= abs_b_s;
              dz_pend_r <= b_zero_s;
              // A zero divisor skips CALC; FIX then only raises done and the flag.
              state_r   <= b_zero_s ? FIX : CALC;
            end else begin
              mcand_r   <= {{WIDTH{1'b0}}, abs_a_s};
              mplier_r  <= abs_b_s;
              divisor_r <= {WIDTH{1'b0}};
              dz_pend_r <= 1'b0;
              state_r   <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        CALC: begin
          if (mul_empty_s) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
            if (is_div_r) begin
              rem_r    <= rem_next_s;
              mplier_r <= quo_next_s;
            end else begin
              prod_r   <= prod_next_s;
              mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
              mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            end
            if (cnt_last_s) state_r <= FIX;
          end
        end

        FIX: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= DONE;
          if (dz_pend_r) begin
            dz_r <= 1'b1;
          end else if (is_div_r) begin
            lo_r <= neg_res_r ? neg_w(mplier_r) : mplier_r;
            hi_r <= neg_rem_r ? neg_w(rem_r) : rem_r;
          end else begin
            {hi_r, lo_r} <= neg_res_r ? neg_2w(prod_r) : prod_r;
          end
        end

        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end
endmodule
